// File: rtl/flex_counter_mm.sv
// Multi-mode up/down counter (wrap / saturate / one-shot) between 1 and a runtime rollover value R.
// All outputs registered; one cycle from the enabled edge. Optional prescaler under FLEX_CNT_PRESCALE_EN.
module flex_counter_mm #(
    parameter int NUM_BITS = 6,
    parameter int PRESCALE = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                load,
    input  logic                count_enable,
    input  logic                dir,
    input  logic [1:0]          mode,
    input  logic [NUM_BITS-1:0] load_val,
    input  logic [NUM_BITS-1:0] rollover_val,
    output logic [NUM_BITS-1:0] count_out,
    output logic                rollover_flag,
    output logic                done
);
    typedef enum logic {RUN, DONE} state_t;

    localparam logic [NUM_BITS-1:0] ONE = NUM_BITS'(1);

    state_t              state_q, state_d;
    logic [NUM_BITS-1:0] count_q, count_d, nxt, terminal;
    logic                flag_q, flag_d, done_q, done_d;
    logic                step_req, step, is_wrap, is_oneshot, r_zero;

    assign r_zero     = (rollover_val == '0);
    assign is_wrap    = (mode == 2'b00) || (mode == 2'b11);
    assign is_oneshot = (mode == 2'b10);
    assign terminal   = dir ? ONE : rollover_val;
    assign step_req   = count_enable && (state_q == RUN) && !r_zero;

`ifdef FLEX_CNT_PRESCALE_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    logic [PW-1:0] pre_q, pre_d;
    logic          tick;

    assign tick = (pre_q == PW'(PRESCALE - 1));
    assign step = step_req && tick;

    always_comb begin
        pre_d = pre_q;
        if (clear || load)
            pre_d = '0;
        else if (step_req)
            pre_d = tick ? '0 : pre_q + PW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pre_q <= '0;
        else     pre_q <= pre_d;
    end
`else
    assign step = step_req;
`endif

    // Candidate value for a step; past-terminal handling depends on mode
    always_comb begin
        nxt = count_q;
        if (!dir) begin
            if (count_q < rollover_val) nxt = count_q + ONE;
            else if (is_wrap)           nxt = ONE;
        end else begin
            if (count_q > ONE)          nxt = count_q - ONE;
            else if (count_q == '0)     nxt = rollover_val;
            else if (is_wrap)           nxt = rollover_val;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        flag_d  = flag_q;
        done_d  = done_q;
        if (clear) begin
            state_d = RUN;
            count_d = '0;
            flag_d  = 1'b0;
            done_d  = 1'b0;
        end else if (load) begin
            state_d = RUN;
            count_d = load_val;
            flag_d  = (load_val == terminal);
            done_d  = 1'b0;
        end else if (step) begin
            count_d = nxt;
            flag_d  = (nxt == terminal);
            if (is_oneshot && (nxt == terminal)) begin
                state_d = DONE;
                done_d  = 1'b1;
            end
        end else if (count_enable && r_zero) begin
            flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            count_q <= '0;
            flag_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            flag_q  <= flag_d;
            done_q  <= done_d;
        end
    end

    assign count_out     = count_q;
    assign rollover_flag = flag_q;
    assign done          = done_q;
endmodule

// File: tb/tb_flex_counter_mm.sv
// Scoreboard bench for flex_counter_mm: expectations queued as stimulus is driven, popped after each edge.
module tb_flex_counter_mm;
    logic       tb_clk = 1'b0;
    logic       rst = 1'b0;
    logic       clear = 1'b0, load = 1'b0, count_enable = 1'b0, dir = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [5:0] load_val = '0, rollover_val = '0;
    logic [5:0] count_out;
    logic       rollover_flag, done;

    typedef struct packed {
        logic [5:0] cnt;
        logic       flag;
        logic       dn;
    } exp_t;

    exp_t exp_q[$];
    exp_t got;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 tb_clk = ~tb_clk;

    flex_counter_mm #(.NUM_BITS(6), .PRESCALE(4)) dut (
        .clk(tb_clk), .rst(rst), .clear(clear), .load(load),
        .count_enable(count_enable), .dir(dir), .mode(mode),
        .load_val(load_val), .rollover_val(rollover_val),
        .count_out(count_out), .rollover_flag(rollover_flag), .done(done)
    );

    task automatic push(input int c, input bit f, input bit d);
        exp_q.push_back({6'(c), f, d});
    endtask

    task automatic set_in(input bit c, input bit l, input bit en, input bit dr,
                          input logic [1:0] md, input int lv, input int rv);
        clear = c; load = l; count_enable = en; dir = dr;
        mode = md; load_val = 6'(lv); rollover_val = 6'(rv);
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1 push(0, 0, 0);
        got = exp_q.pop_front(); n_tests++;
        if (count_out !== got.cnt || rollover_flag !== got.flag || done !== got.dn) begin
            n_fail++;
            $display("FAIL reset_init: got cnt=%0d flag=%b done=%b, expected cnt=%0d flag=%b done=%b",
                     count_out, rollover_flag, done, got.cnt, got.flag, got.dn);
        end
        @(negedge tb_clk) rst = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            set_in(0, 0, 1, 0, 2'b00, 0, 32);
            push(i, 0, 0);
            @(posedge tb_clk); #1;
            got = exp_q.pop_front(); n_tests++;
            if (count_out !== got.cnt || rollover_flag !== got.flag || done !== got.dn) begin
                n_fail++;
                $display("FAIL reset_precount[%0d]: got cnt=%0d flag=%b done=%b, expected cnt=%0d flag=%b done=%b",
                         i, count_out, rollover_flag, done, got.cnt, got.flag, got.dn);
            end
        end
        // Async assertion between edges must clear outputs without a clock
        #2 rst = 1'b1;
        #1 push(0, 0, 0);
        got = exp_q.pop_front(); n_tests++;
        if (count_out !== got.cnt || rollover_flag !== got.flag || done !== got.dn) begin
            n_fail++;
            $display("FAIL reset_async_mid: got cnt=%0d flag=%b done=%b, expected cnt=%0d flag=%b done=%b",
                     count_out, rollover_flag, done, got.cnt, got.flag, got.dn);
        end
        set_in(0, 0, 0, 0, 2'b00, 0, 32);
        @(negedge tb_clk) rst = 1'b0;
        @(posedge tb_clk); #1;
    endtask

    task automatic test_wrap_up();
        for (int i = 1; i <= 33; i++) begin
            set_in(0, 0, 1, 0, (i % 2) ? 2'b00 : 2'b11, 0, 32);
            push((i == 33) ? 1 : i, i == 32, 0);
            @(posedge tb_clk); #1;
            got = exp_q.pop_front(); n_tests++;
            if (count_out !== got.cnt || rollover_flag !== got.flag || done !== got.dn) begin
                n_fail++;
                $display("FAIL wrap_up[%0d]: got cnt=%0d flag=%b done=%b, expected cnt=%0d flag=%b done=%b",
                         i, count_out, rollover_flag, done, got.cnt, got.flag, got.dn);
            end
        end
    endtask

    task automatic test_wrap_down();
        int seq_c[7] = '{3, 2, 1, 5, 4, 0, 0};
        bit seq_f[7] = '{0, 0, 1, 0, 0, 0, 0};
        for (int i = 0; i < 7; i++) begin
            case (i)
                0:       set_in(0, 1, 0, 1, 2'b00, 3, 5);
                5:       set_in(1, 1, 1, 1, 2'b00, 9, 5);
                6:       set_in(0, 0, 0, 1, 2'b00, 0, 5);
                default: set_in(0, 0, 1, 1, 2'b00, 0, 5);
            endcase
            push(seq_c[i], seq_f[i], 0);
            @(posedge tb_clk); #1;
            got = exp_q.pop_front(); n_tests++;
            if (count_out !== got.cnt || rollover_flag !== got.flag || done !== got.dn) begin
                n_fail++;
                $display("FAIL wrap_down[%0d]: got cnt=%0d flag=%b done=%b, expected cnt=%0d flag=%b done=%b",
                         i, count_out, rollover_flag, done, got.cnt, got.flag, got.dn);
            end
        end
    endtask

    task automatic test_sat();
        for (int i = 1; i <= 13; i++) begin
            set_in(0, 0, 1, i == 13, 2'b01, 0, 10);
            if (i == 13)     push(9, 0, 0);
            else if (i < 10) push(i, 0, 0);
            else             push(10, 1, 0);
            @(posedge tb_clk); #1;
            got = exp_q.pop_front(); n_tests++;
            if (count_out !== got.cnt || rollover_flag !== got.flag || done !== got.dn) begin
                n_fail++;
                $display("FAIL sat[%0d]: got cnt=%0d flag=%b done=%b, expected cnt=%0d flag=%b done=%b",
                         i, count_out, rollover_flag, done, got.cnt, got.flag, got.dn);
            end
        end
    endtask

    task automatic test_oneshot();
        int seq_c[11] = '{0, 1, 2, 3, 4, 4, 4, 4, 2, 3, 4};
        bit seq_f[11] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1};
        bit seq_d[11] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1};
        for (int i = 0; i < 11; i++) begin
            if (i == 0)      set_in(1, 0, 0, 0, 2'b10, 0, 4);
            else if (i == 8) set_in(0, 1, 1, 0, 2'b10, 2, 4);
            else             set_in(0, 0, 1, 0, 2'b10, 0, 4);
            push(seq_c[i], seq_f[i], seq_d[i]);
            @(posedge tb_clk); #1;
            got = exp_q.pop_front(); n_tests++;
            if (count_out !== got.cnt || rollover_flag !== got.flag || done !== got.dn) begin
                n_fail++;
                $display("FAIL oneshot[%0d]: got cnt=%0d flag=%b done=%b, expected cnt=%0d flag=%b done=%b",
                         i, count_out, rollover_flag, done, got.cnt, got.flag, got.dn);
            end
        end
    endtask

    task automatic test_boundaries();
        // clear, down from 0 -> R, hold on enable=0, load with R=0, R=0 enable, one-shot down to 1
        int seq_c[8] = '{0, 5, 5, 7, 7, 1, 1, 1};
        bit seq_f[8] = '{0, 0, 0, 0, 0, 1, 1, 1};
        bit seq_d[8] = '{0, 0, 0, 0, 0, 1, 1, 0};
        for (int i = 0; i < 8; i++) begin
            case (i)
                0: set_in(1, 0, 0, 1, 2'b00, 0, 5);
                1: set_in(0, 0, 1, 1, 2'b00, 0, 5);
                2: set_in(0, 0, 0, 1, 2'b00, 0, 5);
                3: set_in(0, 1, 0, 0, 2'b00, 7, 0);
                4: set_in(0, 0, 1, 0, 2'b00, 0, 0);
                5: set_in(0, 1, 0, 1, 2'b10, 2, 6);
                6: set_in(0, 0, 1, 1, 2'b10, 0, 6);
                default: set_in(0, 1, 0, 1, 2'b01, 1, 6);
            endcase
            if (i == 5) push(2, 0, 0);
            else        push(seq_c[i], seq_f[i], seq_d[i]);
            if (i == 6) begin
                // extra expectation for the step 2 -> 1 that completes the one-shot
                @(posedge tb_clk); #1;
                got = exp_q.pop_front(); n_tests++;
                if (count_out !== got.cnt || rollover_flag !== got.flag || done !== got.dn) begin
                    n_fail++;
                    $display("FAIL bound[%0d]: got cnt=%0d flag=%b done=%b, expected cnt=%0d flag=%b done=%b",
                             i, count_out, rollover_flag, done, got.cnt, got.flag, got.dn);
                end
                push(1, 1, 1);
            end
            @(posedge tb_clk); #1;
            got = exp_q.pop_front(); n_tests++;
            if (count_out !== got.cnt || rollover_flag !== got.flag || done !== got.dn) begin
                n_fail++;
                $display("FAIL bound[%0d]: got cnt=%0d flag=%b done=%b, expected cnt=%0d flag=%b done=%b",
                         i, count_out, rollover_flag, done, got.cnt, got.flag, got.dn);
            end
        end
    endtask

`ifdef FLEX_CNT_PRESCALE_EN
    task automatic test_prescale();
        int c;
        set_in(1, 0, 0, 0, 2'b00, 0, 3);
        push(0, 0, 0);
        @(posedge tb_clk); #1;
        void'(exp_q.pop_front());
        for (int k = 1; k <= 26; k++) begin
            c = (k <= 12) ? k / 4 : (k == 18 ? 1 : (k > 18 ? 1 : 3));
            if (k == 15 || k == 16)  set_in(0, 0, 0, 0, 2'b00, 0, 3);
            else if (k > 18)         set_in(0, 0, 1, 0, 2'b00, 0, 0);
            else                     set_in(0, 0, 1, 0, 2'b00, 0, 3);
            push(c, (k <= 18) && (c == 3), 0);
            @(posedge tb_clk); #1;
            got = exp_q.pop_front(); n_tests++;
            if (count_out !== got.cnt || rollover_flag !== got.flag || done !== got.dn) begin
                n_fail++;
                $display("FAIL prescale[%0d]: got cnt=%0d flag=%b done=%b, expected cnt=%0d flag=%b done=%b",
                         k, count_out, rollover_flag, done, got.cnt, got.flag, got.dn);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_sat();
        test_oneshot();
        test_boundaries();
`ifdef FLEX_CNT_PRESCALE_EN
        test_prescale();
`endif
        n_tests++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
